// File: rtl/dma_apb_slave_regs.sv
// APB register slave for a single-channel DMA: APB FSM with wait
// states, CTRL/SRC/DST/SIZE/START/STATUS/REMAIN map and a countdown.
module dma_apb_slave_regs #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pclken,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              scan_en,
  output logic              idle,
  output logic              INT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(12'h000);
  localparam logic [ADDR_W-1:0] A_SRC    = ADDR_W'(12'h004);
  localparam logic [ADDR_W-1:0] A_DST    = ADDR_W'(12'h008);
  localparam logic [ADDR_W-1:0] A_SIZE   = ADDR_W'(12'h00C);
  localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(12'h010);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(12'h014);
  localparam logic [ADDR_W-1:0] A_REMAIN = ADDR_W'(12'h018);
  localparam logic [2:0]        WS       = 3'(WAIT_STATES);

  state_t      r_state;
  logic [2:0]  r_wait;
  logic        r_pready;
  logic        r_enable;
  logic        r_int_en;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [15:0] r_size;
  logic        r_done;
  logic        r_busy;
  logic [15:0] r_remain;

  logic        w_sel_ctrl;
  logic        w_sel_src;
  logic        w_sel_dst;
  logic        w_sel_size;
  logic        w_sel_start;
  logic        w_sel_status;
  logic        w_sel_remain;
  logic        w_err;
  logic        w_xfer;
  logic        w_wr;
  logic        w_launch;
  logic        w_abort;
  logic        w_last;
  logic [31:0] w_rdata;

  assign w_sel_ctrl   = (paddr == A_CTRL);
  assign w_sel_src    = (paddr == A_SRC);
  assign w_sel_dst    = (paddr == A_DST);
  assign w_sel_size   = (paddr == A_SIZE);
  assign w_sel_start  = (paddr == A_START);
  assign w_sel_status = (paddr == A_STATUS);
  assign w_sel_remain = (paddr == A_REMAIN);

  assign w_err = (paddr[1:0] != 2'b00)
               | ~(w_sel_ctrl | w_sel_src | w_sel_dst | w_sel_size
                 | w_sel_start | w_sel_status | w_sel_remain)
               | (w_sel_remain & pwrite);

  assign w_xfer   = psel & penable & r_pready;
  assign w_wr     = w_xfer & pwrite & ~w_err & ~scan_en;
  assign w_launch = w_wr & w_sel_start & pwdata[0]
                  & r_enable & (r_size != 16'd0) & ~r_busy;
  assign w_abort  = w_wr & w_sel_ctrl & ~pwdata[0] & r_busy;
  assign w_last   = r_busy & (r_remain <= 16'd1) & ~w_abort;

  assign pready  = r_pready;
  assign pslverr = w_xfer & w_err;
  assign prdata  = (w_xfer & ~pwrite & ~w_err) ? w_rdata : 32'd0;
  assign idle    = ~r_busy;
  assign INT     = r_done & r_int_en;

  // Read-data mux over the decoded register selects
  always_comb begin
    w_rdata = 32'd0;
    unique case (1'b1)
      w_sel_ctrl:   w_rdata = {30'd0, r_int_en, r_enable};
      w_sel_src:    w_rdata = r_src;
      w_sel_dst:    w_rdata = r_dst;
      w_sel_size:   w_rdata = {16'd0, r_size};
      w_sel_status: w_rdata = {30'd0, r_busy, r_done};
      w_sel_remain: w_rdata = {16'd0, r_remain};
      default:      w_rdata = 32'd0;
    endcase
  end

  // APB phase tracker; pready is registered and gated by pclken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wait   <= 3'd0;
      r_pready <= 1'b0;
    end else if (pclken) begin
      unique case (r_state)
        S_IDLE: begin
          if (psel && !penable) r_state <= S_SETUP;
        end
        S_SETUP: begin
          r_state  <= S_ACCESS;
          r_wait   <= WS;
          r_pready <= (WS == 3'd0);
        end
        S_ACCESS: begin
          if (r_wait != 3'd0) begin
            r_wait   <= r_wait - 3'd1;
            r_pready <= (r_wait == 3'd1);
          end else begin
            r_state  <= S_IDLE;
            r_pready <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_pready <= 1'b0;
        end
      endcase
    end
  end

  // Configuration registers; address/size frozen while a transfer runs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b0;
      r_int_en <= 1'b0;
      r_src    <= 32'd0;
      r_dst    <= 32'd0;
      r_size   <= 16'd0;
    end else begin
      if (w_wr && w_sel_ctrl) begin
        r_enable <= pwdata[0];
        r_int_en <= pwdata[1];
      end
      if (w_wr && !r_busy) begin
        if (w_sel_src)  r_src  <= pwdata;
        if (w_sel_dst)  r_dst  <= pwdata;
        if (w_sel_size) r_size <= pwdata[15:0];
      end
    end
  end

  // Transfer countdown: launch, decrement, finish or abort on disable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_remain <= 16'd0;
    end else if (w_abort) begin
      r_busy   <= 1'b0;
      r_remain <= 16'd0;
    end else if (w_launch) begin
      r_busy   <= 1'b1;
      r_remain <= r_size;
    end else if (r_busy) begin
      r_remain <= r_remain - 16'd1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  // Done flag: set on completion wins over a same-cycle W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else if (w_last) begin
      r_done <= 1'b1;
    end else if (w_wr && w_sel_status && pwdata[0]) begin
      r_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_apb_slave_regs.sv
// Scoreboard bench for dma_apb_slave_regs: APB master tasks push
// expected responses, a negedge monitor pops and compares them.
module tb_dma_apb_slave_regs;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        pclken;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [12:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        scan_en;
  logic        idle;
  logic        INT;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  dma_apb_slave_regs #(.WAIT_STATES(WS), .ADDR_W(13)) dut (
    .clk(clk), .reset(reset), .pclken(pclken),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .scan_en(scan_en),
    .idle(idle), .INT(INT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (psel && penable && pready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("prdata", prdata, e.data);
        chk("pslverr", {31'd0, pslverr}, {31'd0, e.err});
      end
    end else if (psel && penable) begin
      chk("prdata_wait", prdata, 32'd0);
    end
  end

  task automatic apb(input logic wr, input logic [12:0] a,
                     input logic [31:0] d, input logic [31:0] ed,
                     input logic ee, input int stall,
                     output int lowcnt);
    int n;
    q.push_back('{err: ee, data: (wr ? 32'd0 : ed)});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    lowcnt = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      lowcnt++;
      if (stall > 0 && lowcnt == 1 + WS) pclken = 1'b0;
      if (stall > 0 && lowcnt == 1 + WS + stall) pclken = 1'b1;
      n++;
      if (n > 50) begin
        chk("pready_timeout", 32'd0, 32'd1);
        void'(q.pop_back());
        pclken = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_reg(input logic [12:0] a, input logic [31:0] d,
                        input logic ee);
    int lc;
    apb(1'b1, a, d, 32'd0, ee, 0, lc);
  endtask

  task automatic rd_reg(input logic [12:0] a, input logic [31:0] ed,
                        input logic ee);
    int lc;
    apb(1'b0, a, 32'd0, ed, ee, 0, lc);
  endtask

  initial begin
    int lc;
    int k;
    reset = 1'b1; pclken = 1'b1; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; scan_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_int", {31'd0, INT}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    reset = 1'b0;

    // CTRL write/readback; SETUP cycle plus WS wait cycles low
    wr_reg(13'h000, 32'h3, 1'b0);
    apb(1'b0, 13'h000, 32'd0, 32'h3, 1'b0, 0, lc);
    chk("lowcnt", lc, 1 + WS);
    wr_reg(13'h004, 32'hDEAD_BEEF, 1'b0);
    wr_reg(13'h008, 32'h1234_5678, 1'b0);
    rd_reg(13'h004, 32'hDEAD_BEEF, 1'b0);
    rd_reg(13'h008, 32'h1234_5678, 1'b0);

    // pclken stall of 3 cycles inside ACCESS
    apb(1'b0, 13'h008, 32'd0, 32'h1234_5678, 1'b0, 3, lc);
    chk("lowcnt_stall", lc, 1 + WS + 3);

    // Transfer of 4
    wr_reg(13'h00C, 32'h4, 1'b0);
    wr_reg(13'h010, 32'h1, 1'b0);
    for (k = 4; k >= 0; k--) begin
      @(negedge clk);
      chk("remain_seq", {16'd0, dut.r_remain}, k);
      chk("idle_seq", {31'd0, idle}, (k == 0) ? 32'd1 : 32'd0);
    end
    chk("int_set", {31'd0, INT}, 32'd1);
    rd_reg(13'h014, 32'h1, 1'b0);
    rd_reg(13'h018, 32'h0, 1'b0);
    rd_reg(13'h010, 32'h0, 1'b0);
    wr_reg(13'h014, 32'h1, 1'b0);
    @(negedge clk);
    chk("int_clr", {31'd0, INT}, 32'd0);

    // Error accesses change nothing
    rd_reg(13'h01C, 32'h0, 1'b1);
    wr_reg(13'h002, 32'h0, 1'b1);
    wr_reg(13'h018, 32'h5, 1'b1);
    rd_reg(13'h000, 32'h3, 1'b0);
    rd_reg(13'h018, 32'h0, 1'b0);

    // START ignored with SIZE=0
    wr_reg(13'h00C, 32'h0, 1'b0);
    wr_reg(13'h010, 32'h1, 1'b0);
    @(negedge clk);
    chk("start_size0", {31'd0, idle}, 32'd1);

    // Abort by disabling mid-transfer
    wr_reg(13'h00C, 32'hA, 1'b0);
    wr_reg(13'h010, 32'h1, 1'b0);
    wr_reg(13'h000, 32'h2, 1'b0);
    @(negedge clk);
    chk("abort_idle", {31'd0, idle}, 32'd1);
    rd_reg(13'h014, 32'h0, 1'b0);
    rd_reg(13'h018, 32'h0, 1'b0);

    // SIZE frozen while busy, scan_en blocks CTRL write
    wr_reg(13'h000, 32'h3, 1'b0);
    wr_reg(13'h00C, 32'h28, 1'b0);
    wr_reg(13'h010, 32'h1, 1'b0);
    wr_reg(13'h00C, 32'h9, 1'b0);
    scan_en = 1'b1;
    wr_reg(13'h000, 32'h0, 1'b0);
    scan_en = 1'b0;
    rd_reg(13'h00C, 32'h28, 1'b0);
    rd_reg(13'h000, 32'h3, 1'b0);
    chk("busy_kept", {31'd0, idle}, 32'd0);

    // Asynchronous reset when REMAIN=2
    k = 0;
    while (dut.r_remain != 16'd2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_rem2", {16'd0, dut.r_remain}, 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_remain", {16'd0, dut.r_remain}, 32'd0);
    chk("rst_idle2", {31'd0, idle}, 32'd1);
    chk("rst_int2", {31'd0, INT}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_reg(13'h000, 32'h0, 1'b0);
    rd_reg(13'h00C, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drain", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
